// File: rtl/hilo_pkg.sv
// hilo_pkg: shared definitions for the HI/LO register unit.
//   - op encodings presented on the op port
//   - controller state enumeration
//   - divider iteration count and divide-by-zero LO value
//   - abs32: two's-complement magnitude (0x80000000 maps to itself)
package hilo_pkg;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam int DIV_CYCLES = 32;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_ITER = 2'd2,
        DIV_FIX  = 2'd3
    } state_t;

    // Magnitude of a signed 32-bit value; the most negative value wraps to
    // itself, which is the correct unsigned magnitude 2^31.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/hilo_div_iter.sv
// div_iter: unsigned restoring divider core, one quotient bit per cycle.
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   start          load dividend/divisor and begin DIV_CYCLES iterations
//   dividend       unsigned dividend (sampled on start)
//   divisor        unsigned divisor, must be non-zero (sampled on start)
//   quotient       quotient register (final once done has been seen)
//   remainder      partial/final remainder register
//   done           high during the cycle of the last iteration
module div_iter
    import hilo_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        done
);

    localparam int CNT_W = $clog2(DIV_CYCLES);

    logic [31:0]      quo;
    logic [31:0]      rem;
    logic [31:0]      dsr;
    logic [CNT_W-1:0] cnt;
    logic             running;

    // Bring the next dividend bit into the remainder and try a subtract.
    // rem < dsr always holds, so the shifted value fits in 33 bits and a
    // non-negative trial result fits back into 32.
    logic [32:0] shifted;
    logic [32:0] trial;

    always_comb begin
        shifted = {rem, quo[31]};
        trial   = shifted - {1'b0, dsr};
    end

    assign done      = running && (cnt == CNT_W'(DIV_CYCLES - 1));
    assign quotient  = quo;
    assign remainder = rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo     <= '0;
            rem     <= '0;
            dsr     <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            quo     <= dividend;
            rem     <= '0;
            dsr     <= divisor;
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            if (trial[32]) begin
                rem <= shifted[31:0];
                quo <= {quo[30:0], 1'b0};
            end else begin
                rem <= trial[31:0];
                quo <= {quo[30:0], 1'b1};
            end
            cnt <= cnt + 1'b1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: architectural HI/LO registers with multiply/divide sequencing.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   op_valid/op_ready   request handshake: an op is taken on a rising edge
//                       where op_valid && op_ready; op_ready is high only
//                       in IDLE, and the requester holds op/rs/rt stable
//                       until it is taken
//   op, rs_data,rt_data operation code and operands
//   mul_a, mul_b        registered operand magnitudes to external multiplier
//   mul_p               product returned by the external multiplier
//   mf_req, mf_sel      MFHI/MFLO read request, 1 = HI, 0 = LO
//   mf_data             selected HI/LO value (combinational)
//   busy, stall         operation in flight / pipeline must hold
//   hi, lo              architectural HI and LO
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int MUL_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        op_ready,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_p,
    input  logic        mf_req,
    input  logic        mf_sel,
    output logic [31:0] mf_data,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

    state_t           state;
    logic [CNT_W-1:0] mul_cnt;
    logic             mul_neg;   // product must be negated
    logic             quo_neg;   // quotient must be negated
    logic             rem_neg;   // remainder takes the dividend's sign
    logic             div_zero;  // current divide had a zero divisor
    logic [31:0]      zero_hi;   // dividend captured for the zero-divisor result

    logic        accept;
    logic        is_signed;
    logic        div_start;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic        div_done;

    assign accept    = op_valid && (state == IDLE);
    assign is_signed = (op == OP_MULT) || (op == OP_DIV);
    assign mag_a     = is_signed ? abs32(rs_data) : rs_data;
    assign mag_b     = is_signed ? abs32(rt_data) : rt_data;
    assign div_start = accept && ((op == OP_DIV) || (op == OP_DIVU)) && (rt_data != '0);

    assign op_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign stall    = (mf_req || op_valid) && busy;
    assign mf_data  = mf_sel ? hi : lo;

    div_iter u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (div_quo),
        .remainder (div_rem),
        .done      (div_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hi       <= '0;
            lo       <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            mul_cnt  <= '0;
            mul_neg  <= 1'b0;
            quo_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            div_zero <= 1'b0;
            zero_hi  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_MTHI: hi <= rs_data;
                            OP_MTLO: lo <= rs_data;
                            OP_MULT, OP_MULTU: begin
                                mul_a   <= mag_a;
                                mul_b   <= mag_b;
                                mul_neg <= (op == OP_MULT) && (rs_data[31] ^ rt_data[31]);
                                mul_cnt <= CNT_W'(MUL_LATENCY - 1);
                                state   <= MUL_WAIT;
                            end
                            OP_DIV, OP_DIVU: begin
                                quo_neg  <= (op == OP_DIV) && (rs_data[31] ^ rt_data[31]);
                                rem_neg  <= (op == OP_DIV) && rs_data[31];
                                div_zero <= (rt_data == '0);
                                zero_hi  <= rs_data;
                                // A zero divisor skips the iterations entirely.
                                state    <= (rt_data == '0) ? DIV_FIX : DIV_ITER;
                            end
                            default: ;
                        endcase
                    end
                end
                MUL_WAIT: begin
                    // mul_p has had MUL_LATENCY cycles to settle from mul_a/mul_b.
                    if (mul_cnt == '0) begin
                        {hi, lo} <= mul_neg ? (~mul_p + 64'd1) : mul_p;
                        state    <= IDLE;
                    end else begin
                        mul_cnt <= mul_cnt - 1'b1;
                    end
                end
                DIV_ITER: begin
                    if (div_done) begin
                        state <= DIV_FIX;
                    end
                end
                DIV_FIX: begin
                    if (div_zero) begin
                        hi <= zero_hi;
                        lo <= DIV0_LO;
                    end else begin
                        lo <= quo_neg ? (~div_quo + 32'd1) : div_quo;
                        hi <= rem_neg ? (~div_rem + 32'd1) : div_rem;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: directed and random checks of hilo_unit against a
// behavioural model of the HI/LO architectural effects.
module tb_hilo_unit;

    localparam int LAT = 4;

    localparam logic [2:0] T_NOP   = 3'b000;
    localparam logic [2:0] T_MULT  = 3'b001;
    localparam logic [2:0] T_MULTU = 3'b010;
    localparam logic [2:0] T_DIV   = 3'b011;
    localparam logic [2:0] T_DIVU  = 3'b100;
    localparam logic [2:0] T_MTHI  = 3'b101;
    localparam logic [2:0] T_MTLO  = 3'b110;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        op_ready;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_p;
    logic        mf_req;
    logic        mf_sel;
    logic [31:0] mf_data;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    // Model of architectural HI/LO.
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    hilo_unit #(.MUL_LATENCY(LAT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_valid (op_valid),
        .op       (op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .op_ready (op_ready),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_p    (mul_p),
        .mf_req   (mf_req),
        .mf_sel   (mf_sel),
        .mf_data  (mf_data),
        .busy     (busy),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo)
    );

    // External unsigned combinational multiplier.
    assign mul_p = {32'd0, mul_a} * {32'd0, mul_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Architectural result of an op, from plain integer arithmetic.
    task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            output int exp_busy);
        longint sa, sb, q, r, p;
        logic [63:0] up;
        sa = $signed(a);
        sb = $signed(b);
        exp_busy = 0;
        case (o)
            T_MULT: begin
                p = sa * sb;
                {m_hi, m_lo} = p;
                exp_busy = LAT;
            end
            T_MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                {m_hi, m_lo} = up;
                exp_busy = LAT;
            end
            T_DIV, T_DIVU: begin
                if (b == 0) begin
                    m_hi = a;
                    m_lo = 32'hFFFF_FFFF;
                    exp_busy = 1;
                end else begin
                    if (o == T_DIVU) begin
                        sa = {32'd0, a};
                        sb = {32'd0, b};
                    end
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                    exp_busy = 33;
                end
            end
            T_MTHI: m_hi = a;
            T_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b);
        int          eb;
        int          n;
        bit          done;
        logic [31:0] old_hi, old_lo, ea, eb_mag;
        logic        sel;
        old_hi = m_hi;
        old_lo = m_lo;
        model_op(o, a, b, eb);
        ea     = (o == T_MULT && a[31]) ? (32'd0 - a) : a;
        eb_mag = (o == T_MULT && b[31]) ? (32'd0 - b) : b;
        @(negedge clk);
        chk({tag, "_ready"}, op_ready, 1'b1);
        op_valid = 1'b1;
        op       = o;
        rs_data  = a;
        rt_data  = b;
        mf_req   = 1'b0;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        if (o == T_MULT || o == T_MULTU) begin
            chk({tag, "_mul_a"}, mul_a, ea);
            chk({tag, "_mul_b"}, mul_b, eb_mag);
        end
        n    = 0;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (busy) begin
                n++;
                if (n == 1) begin
                    // A second request while busy is refused and stalls.
                    op_valid = 1'b1;
                    #1;
                    chk({tag, "_busy_ready"}, op_ready, 1'b0);
                    chk({tag, "_busy_stall_op"}, stall, 1'b1);
                    op_valid = 1'b0;
                end
                sel    = 1'($urandom_range(0, 1));
                mf_sel = sel;
                mf_req = 1'b1;
                #1;
                chk({tag, "_busy_stall_mf"}, stall, 1'b1);
                chk({tag, "_busy_old_mf"}, mf_data, sel ? old_hi : old_lo);
                mf_req = 1'b0;
            end else begin
                done = 1'b1;
            end
        end
        chk({tag, "_busy_cycles"}, n, eb);
        chk({tag, "_hi"}, hi, m_hi);
        chk({tag, "_lo"}, lo, m_lo);
        sel    = 1'($urandom_range(0, 1));
        mf_sel = sel;
        mf_req = 1'b1;
        #1;
        chk({tag, "_mf_after"}, mf_data, sel ? m_hi : m_lo);
        chk({tag, "_stall_after"}, stall, 1'b0);
        mf_req = 1'b0;
    endtask

    initial begin
        int          pick;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        rst_n    = 1'b0;
        op_valid = 1'b0;
        op       = T_NOP;
        rs_data  = '0;
        rt_data  = '0;
        mf_req   = 1'b0;
        mf_sel   = 1'b0;
        #12;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_mul_a", mul_a, 32'd0);
        chk("rst_mul_b", mul_b, 32'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", op_ready, 1'b1);
        chk("rst_stall", stall, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        run_op("multu_max", T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_max_hi_const", hi, 32'hFFFF_FFFE);
        chk("multu_max_lo_const", lo, 32'h0000_0001);
        run_op("mult_m3x7", T_MULT, 32'hFFFF_FFFD, 32'd7);
        chk("mult_m3x7_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("mult_minint", T_MULT, 32'h8000_0000, 32'd3);
        run_op("div_m7_2", T_DIV, 32'hFFFF_FFF9, 32'd2);
        chk("div_m7_2_lo_const", lo, 32'hFFFF_FFFD);
        chk("div_m7_2_hi_const", hi, 32'hFFFF_FFFF);
        run_op("divu_7_2", T_DIVU, 32'd7, 32'd2);
        chk("divu_7_2_const", {hi, lo}, {32'd1, 32'd3});
        run_op("div_5_0", T_DIV, 32'd5, 32'd0);
        chk("div_5_0_const", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
        run_op("div_ovf", T_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_const", {hi, lo}, {32'd0, 32'h8000_0000});
        run_op("div_7_m2", T_DIV, 32'd7, 32'hFFFF_FFFE);
        run_op("mtlo", T_MTLO, 32'h0000_1234, 32'd0);
        chk("mtlo_const", lo, 32'h0000_1234);
        run_op("mthi", T_MTHI, 32'hCAFE_0001, 32'd0);
        run_op("nop", T_NOP, 32'h1111_1111, 32'h2222_2222);
        run_op("unused", 3'b111, 32'h3333_3333, 32'h4444_4444);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        op_valid = 1'b1;
        op       = T_DIV;
        rs_data  = 32'd1000;
        rt_data  = 32'd7;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_ready", op_ready, 1'b1);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst_multu", T_MULTU, 32'd2, 32'd3);
        chk("post_rst_lo_const", lo, 32'd6);

        // Random operations.
        for (int i = 0; i < 30; i++) begin
            pick = $urandom_range(0, 7);
            ro   = 3'(pick);
            ra   = $urandom;
            rb   = $urandom;
            if ($urandom_range(0, 5) == 0) rb = '0;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 15));
            run_op("rand", ro, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
